handshake_sync_arbiter: RTL

//   Round-robin arbiter that shares one handshake_synchronizer source port among NUM_REQ requesters
//   in the source clock domain. It latches the winning requester's word and issues a one-cycle

---
 rtl/handshake_sync_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/handshake_sync_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : handshake_sync_arbiter
// Brief    : Round-robin arbiter that shares one handshake_synchronizer
//            source port among NUM_REQ source-domain requesters. It latches the
//            winner's word, issues a one-cycle valid pulse and follows
//            sync_busy_i through to completion. It returns a one-cycle ack,
//            or a one-cycle err if busy never rises within BUSY_TIMEOUT cycles.
// Config   : HS_ARB_ID_TAG_EN - when defined, sync_data_o carries
//            {grant_id, data} so the destination can demux by requester.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_sync_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              ack_o,
  output logic                            err_o,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id_o,
  input  logic                            sync_busy_i,
  output logic                            sync_valid_o,
`ifdef HS_ARB_ID_TAG_EN
  output logic [DATA_WIDTH+$clog2(NUM_REQ)-1:0] sync_data_o
`else
  output logic [DATA_WIDTH-1:0]           sync_data_o
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(BUSY_TIMEOUT);
`ifdef HS_ARB_ID_TAG_EN
  localparam int SYNC_W = DATA_WIDTH + IDW;
`else
  localparam int SYNC_W = DATA_WIDTH;
`endif

  localparam logic [IDW-1:0] c_last_id = IDW'(NUM_REQ - 1);
  // The abort fires on the cycle the timer would step onto BUSY_TIMEOUT-1.
  localparam logic [TW-1:0]  c_timer_last = TW'(BUSY_TIMEOUT - 2);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      grant_id_q;
  logic [SYNC_W-1:0]   data_q;
  logic [TW-1:0]       timer_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                err_q;
  logic                valid_q;

  logic                  w_arb_hit;
  logic [IDW-1:0]        w_arb_id;
  logic [IDW-1:0]        w_cand_id;
  logic [DATA_WIDTH-1:0] w_arb_data;
  logic [IDW-1:0]        w_next_ptr;
  int                    w_cand;

  // Round-robin search: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_id  = '0;
    w_cand    = 0;
    w_cand_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = int'(rr_ptr_q) + i;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      w_cand_id = IDW'(w_cand);
      if (!w_arb_hit && req_i[w_cand_id]) begin
        w_arb_hit = 1'b1;
        w_arb_id  = w_cand_id;
      end
    end
  end

  assign w_arb_data = req_data_i[int'(w_arb_id)*DATA_WIDTH +: DATA_WIDTH];
  assign w_next_ptr = (grant_id_q == c_last_id) ? '0 : grant_id_q + 1'b1;

  // Transfer sequencer: grant, issue pulse, follow busy, then ack or abort.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      ack_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A busy synchronizer still owns the previous word; hold off.
          if (w_arb_hit && !sync_busy_i) begin
            grant_id_q <= w_arb_id;
`ifdef HS_ARB_ID_TAG_EN
            data_q     <= {w_arb_id, w_arb_data};
`else
            data_q     <= w_arb_data;
`endif
            valid_q    <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (sync_busy_i) begin
            state_q <= ST_WAIT_DONE;
          end else if (timer_q == c_timer_last) begin
            err_q    <= 1'b1;
            rr_ptr_q <= w_next_ptr;
            state_q  <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!sync_busy_i) begin
            ack_q[grant_id_q] <= 1'b1;
            rr_ptr_q          <= w_next_ptr;
            state_q           <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign grant_id_o   = grant_id_q;
  assign sync_valid_o = valid_q;
  assign sync_data_o  = data_q;

endmodule
`default_nettype wire
